// File: rtl/fifo_umbral_ctrl_pkg.sv
// Shared defaults for the buffer FIFOs: widths/depths per buffer class, threshold
// defaults, status-vector bit order and the controller state type.
package fifo_umbral_ctrl_pkg;

  localparam int unsigned FIFO_DATA_W = 6;

  // Pointer widths per buffer class (depth = 2**ADDR_W)
  localparam int unsigned MF_ADDR_W = 2;
  localparam int unsigned VC_ADDR_W = 4;
  localparam int unsigned D_ADDR_W  = 2;

  localparam int unsigned DEF_UMB_BAJO = 1;
  localparam int unsigned DEF_UMB_ALTO = 12;

  // Bit positions in the 5-bit FIFO_empty / FIFO_error vectors: {MF,VC0,VC1,D0,D1}
  localparam int unsigned STAT_W      = 5;
  localparam int unsigned STAT_IDX_MF  = 4;
  localparam int unsigned STAT_IDX_VC0 = 3;
  localparam int unsigned STAT_IDX_VC1 = 2;
  localparam int unsigned STAT_IDX_D0  = 1;
  localparam int unsigned STAT_IDX_D1  = 0;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } ctrl_state_t;

  function automatic int unsigned depth_of(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/fifo_umbral_ctrl_if.sv
// Push/pop handshake plus status bundle between a buffer FIFO and its user.
interface fifo_umbral_ctrl_if #(
  parameter int unsigned DATA_W = 6,
  parameter int unsigned ADDR_W = 4
);

  logic              push;
  logic [DATA_W-1:0] data_in;
  logic              pop;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic              fifo_empty;
  logic              fifo_full;
  logic              almost_empty;
  logic              almost_full;
  logic              fifo_error;
  logic [ADDR_W:0]   count;

  modport master (
    output push, data_in, pop,
    input  data_out, valid_out, fifo_empty, fifo_full,
           almost_empty, almost_full, fifo_error, count
  );

  modport slave (
    input  push, data_in, pop,
    output data_out, valid_out, fifo_empty, fifo_full,
           almost_empty, almost_full, fifo_error, count
  );

endinterface

// File: rtl/fifo_umbral_ctrl_mem.sv
// DEPTH x DATA_W register file: one write port, one registered read port.
// Storage is not reset; only the read register is.
module fifo_mem
  import fifo_umbral_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = FIFO_DATA_W,
  parameter int unsigned ADDR_W = VC_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = depth_of(ADDR_W);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read register holds its value when no read is issued
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/fifo_umbral_ctrl.sv
// Synchronous FIFO with programmable almost-empty/almost-full thresholds captured
// on init, and a sticky overflow error cleared only by reset or init.
module fifo_umbral_ctrl
  import fifo_umbral_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W    = FIFO_DATA_W,
  parameter int unsigned ADDR_W    = VC_ADDR_W,
  parameter int unsigned UMB_B_DEF = DEF_UMB_BAJO,
  parameter int unsigned UMB_A_DEF = DEF_UMB_ALTO
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic [ADDR_W-1:0] umbral_bajo,
  input  logic [ADDR_W-1:0] umbral_alto,
  fifo_umbral_ctrl_if.slave bus
);

  localparam int unsigned DEPTH = depth_of(ADDR_W);
  localparam int unsigned CNT_W = ADDR_W + 1;

  ctrl_state_t       state_q;
  ctrl_state_t       state_d;
  logic              flush_c;
  logic              push_acc_c;
  logic              pop_acc_c;
  logic              overflow_c;
  logic              empty_c;
  logic              full_c;

  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [ADDR_W-1:0] umb_b_q;
  logic [ADDR_W-1:0] umb_a_q;
  logic [CNT_W-1:0]  count_q;
  logic              valid_q;
  logic              error_q;
  logic [DATA_W-1:0] rd_data;

  assign empty_c = (count_q == '0);
  assign full_c  = (count_q == CNT_W'(DEPTH));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Controller: FLUSH while init is held; init always wins over push/pop
  always_comb begin
    state_d    = state_q;
    flush_c    = 1'b0;
    push_acc_c = 1'b0;
    pop_acc_c  = 1'b0;
    overflow_c = 1'b0;

    case (state_q)
      ST_RUN:   if (init)  state_d = ST_FLUSH;
      ST_FLUSH: if (!init) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase

    if (init) begin
      flush_c = 1'b1;
    end else begin
      // A simultaneous pop frees the slot, so a push into a full FIFO is legal then
      pop_acc_c  = bus.pop && !empty_c;
      push_acc_c = bus.push && (!full_c || bus.pop);
      overflow_c = bus.push && full_c && !bus.pop;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
      umb_b_q  <= ADDR_W'(UMB_B_DEF);
      umb_a_q  <= ADDR_W'(UMB_A_DEF);
    end else if (flush_c) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
      umb_b_q  <= umbral_bajo;
      umb_a_q  <= umbral_alto;
    end else begin
      if (push_acc_c) begin
        wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      end
      if (pop_acc_c) begin
        rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
      end
      count_q <= count_q + CNT_W'(push_acc_c) - CNT_W'(pop_acc_c);
      valid_q <= pop_acc_c;
      if (overflow_c) begin
        error_q <= 1'b1;
      end
    end
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (push_acc_c),
    .waddr (wr_ptr_q),
    .wdata (bus.data_in),
    .re    (pop_acc_c),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  // Flags decode registered count/thresholds, so they track count in the same cycle
  assign bus.data_out     = rd_data;
  assign bus.valid_out    = valid_q;
  assign bus.count        = count_q;
  assign bus.fifo_error   = error_q;
  assign bus.fifo_empty   = empty_c;
  assign bus.fifo_full    = full_c;
  assign bus.almost_empty = (count_q <= CNT_W'(umb_b_q));
  assign bus.almost_full  = (count_q >= CNT_W'(umb_a_q));

endmodule

// File: tb/tb_fifo_umbral_ctrl.sv
// Directed bench for fifo_umbral_ctrl: queue-based reference model compared every
// cycle, plus hand-computed literal expectations at key points of each scenario.
module tb_fifo_umbral_ctrl;

  localparam int unsigned DATA_W = 6;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DEPTH  = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              init;
  logic [ADDR_W-1:0] umbral_bajo;
  logic [ADDR_W-1:0] umbral_alto;

  fifo_umbral_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  fifo_umbral_ctrl #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .UMB_B_DEF (1),
    .UMB_A_DEF (12)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .init        (init),
    .umbral_bajo (umbral_bajo),
    .umbral_alto (umbral_alto),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: occupancy is the queue itself
  logic [DATA_W-1:0] mq[$];
  bit                m_err;
  bit                m_valid;
  logic [DATA_W-1:0] m_dout;
  int                m_bajo;
  int                m_alto;
  int                m_n;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      m_err   = 1'b0;
      m_valid = 1'b0;
      m_dout  = '0;
      m_bajo  = 1;
      m_alto  = 12;
    end else if (init) begin
      mq.delete();
      m_err   = 1'b0;
      m_valid = 1'b0;
      m_bajo  = int'(umbral_bajo);
      m_alto  = int'(umbral_alto);
    end else begin
      m_n = mq.size();
      if (bus.pop && m_n != 0) begin
        m_dout  = mq.pop_front();
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
      if (bus.push) begin
        if (m_n < int'(DEPTH) || bus.pop) mq.push_back(bus.data_in);
        else m_err = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cmp_count", 32'(bus.count), 32'(mq.size()));
      check("cmp_empty", 32'(bus.fifo_empty), 32'(mq.size() == 0));
      check("cmp_full", 32'(bus.fifo_full), 32'(mq.size() == int'(DEPTH)));
      check("cmp_almost_empty", 32'(bus.almost_empty), 32'(mq.size() <= m_bajo));
      check("cmp_almost_full", 32'(bus.almost_full), 32'(mq.size() >= m_alto));
      check("cmp_error", 32'(bus.fifo_error), 32'(m_err));
      check("cmp_valid", 32'(bus.valid_out), 32'(m_valid));
      check("cmp_data_out", 32'(bus.data_out), 32'(m_dout));
    end
  end

  task automatic step(input logic p, input logic [DATA_W-1:0] d, input logic po);
    bus.push    = p;
    bus.data_in = d;
    bus.pop     = po;
    @(posedge clk);
    #1;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
  endtask

  task automatic do_init(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] a);
    init        = 1'b1;
    umbral_bajo = b;
    umbral_alto = a;
    @(posedge clk);
    #1;
    init     = 1'b0;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    init        = 1'b0;
    umbral_bajo = '0;
    umbral_alto = '0;
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.data_in = '0;
    #1 reset = 1'b0;
    #11 reset = 1'b1;
    @(posedge clk);
    #1;
    chk_en = 1'b1;

    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_empty", 32'(bus.fifo_empty), 32'd1);
    check("rst_valid", 32'(bus.valid_out), 32'd0);
    check("rst_data_out", 32'(bus.data_out), 32'd0);
    check("rst_error", 32'(bus.fifo_error), 32'd0);

    // T1: fill with thresholds 1/12
    do_init(4'd1, 4'd12);
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, DATA_W'(i), 1'b0);
      if (i == 1)  check("t1_ae_at1", 32'(bus.almost_empty), 32'd1);
      if (i == 2)  check("t1_ae_at2", 32'(bus.almost_empty), 32'd0);
      if (i == 11) check("t1_af_at11", 32'(bus.almost_full), 32'd0);
      if (i == 12) check("t1_af_at12", 32'(bus.almost_full), 32'd1);
    end
    check("t1_count", 32'(bus.count), 32'd16);
    check("t1_full", 32'(bus.fifo_full), 32'd1);

    // T2: overflow, then drain in order
    step(1'b1, 6'h2A, 1'b0);
    check("t2_error", 32'(bus.fifo_error), 32'd1);
    check("t2_count", 32'(bus.count), 32'd16);
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, '0, 1'b1);
      check("t2_pop_data", 32'(bus.data_out), 32'(i));
      check("t2_pop_valid", 32'(bus.valid_out), 32'd1);
    end
    check("t2_error_held", 32'(bus.fifo_error), 32'd1);
    check("t2_empty", 32'(bus.fifo_empty), 32'd1);
    step(1'b0, '0, 1'b0);
    check("t2_idle_valid", 32'(bus.valid_out), 32'd0);
    check("t2_idle_hold", 32'(bus.data_out), 32'h10);
    step(1'b0, '0, 1'b1);
    check("t2_pop_empty_valid", 32'(bus.valid_out), 32'd0);
    check("t2_pop_empty_count", 32'(bus.count), 32'd0);
    do_init(4'd1, 4'd12);
    check("t2_init_clears_err", 32'(bus.fifo_error), 32'd0);

    // T3: push+pop on empty is push only
    step(1'b1, 6'h15, 1'b1);
    check("t3_count", 32'(bus.count), 32'd1);
    check("t3_valid", 32'(bus.valid_out), 32'd0);
    step(1'b0, '0, 1'b1);
    check("t3_data", 32'(bus.data_out), 32'h15);
    check("t3_valid2", 32'(bus.valid_out), 32'd1);

    // T4: push+pop when full, read across pointer wrap
    for (int i = 0; i < 16; i++) step(1'b1, DATA_W'(32 + i), 1'b0);
    step(1'b1, 6'h3F, 1'b1);
    check("t4_count", 32'(bus.count), 32'd16);
    check("t4_error", 32'(bus.fifo_error), 32'd0);
    check("t4_first", 32'(bus.data_out), 32'h20);
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, '0, 1'b1);
      check("t4_drain", 32'(bus.data_out), (i < 16) ? 32'(32 + i) : 32'h3F);
    end

    // T5: init mid-traffic (with push/pop asserted) after an overflow
    for (int i = 0; i < 16; i++) step(1'b1, DATA_W'(i), 1'b0);
    step(1'b1, 6'h07, 1'b0);
    check("t5_pre_error", 32'(bus.fifo_error), 32'd1);
    bus.push    = 1'b1;
    bus.pop     = 1'b1;
    bus.data_in = 6'h09;
    do_init(4'd4, 4'd8);
    check("t5_count", 32'(bus.count), 32'd0);
    check("t5_error", 32'(bus.fifo_error), 32'd0);
    check("t5_empty", 32'(bus.fifo_empty), 32'd1);
    check("t5_valid", 32'(bus.valid_out), 32'd0);
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, DATA_W'(48 + i), 1'b0);
      if (i == 4) check("t5_ae_at4", 32'(bus.almost_empty), 32'd1);
      if (i == 5) check("t5_ae_at5", 32'(bus.almost_empty), 32'd0);
      if (i == 7) check("t5_af_at7", 32'(bus.almost_full), 32'd0);
      if (i == 8) check("t5_af_at8", 32'(bus.almost_full), 32'd1);
    end

    // T6: asynchronous reset between edges with count=7 and valid_out high
    step(1'b0, '0, 1'b1);
    check("t6_pre_count", 32'(bus.count), 32'd7);
    check("t6_pre_valid", 32'(bus.valid_out), 32'd1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("t6_count", 32'(bus.count), 32'd0);
    check("t6_valid", 32'(bus.valid_out), 32'd0);
    check("t6_data_out", 32'(bus.data_out), 32'd0);
    check("t6_error", 32'(bus.fifo_error), 32'd0);
    check("t6_empty", 32'(bus.fifo_empty), 32'd1);
    check("t6_ae", 32'(bus.almost_empty), 32'd1);
    check("t6_af", 32'(bus.almost_full), 32'd0);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, DATA_W'(i), 1'b0);
      if (i == 2)  check("t6_ae_default", 32'(bus.almost_empty), 32'd0);
      if (i == 11) check("t6_af_default11", 32'(bus.almost_full), 32'd0);
      if (i == 12) check("t6_af_default12", 32'(bus.almost_full), 32'd1);
    end

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
